// File: rtl/wb_master_arbiter.sv
// Two-master Wishbone arbiter (instruction fetch = master 0, load/store = master 1)
// onto a single interconnect port. Optional watchdog: define WB_ARB_TIMEOUT_EN.
module wb_master_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,

  input  logic [31:0] wbm0_adr_i,
  input  logic [31:0] wbm0_dat_i,
  input  logic [3:0]  wbm0_sel_i,
  input  logic        wbm0_we_i,
  input  logic        wbm0_cyc_i,
  input  logic        wbm0_stb_i,
  output logic [31:0] wbm0_dat_o,
  output logic        wbm0_ack_o,
  output logic        wbm0_err_o,
  output logic        wbm0_rty_o,

  input  logic [31:0] wbm1_adr_i,
  input  logic [31:0] wbm1_dat_i,
  input  logic [3:0]  wbm1_sel_i,
  input  logic        wbm1_we_i,
  input  logic        wbm1_cyc_i,
  input  logic        wbm1_stb_i,
  output logic [31:0] wbm1_dat_o,
  output logic        wbm1_ack_o,
  output logic        wbm1_err_o,
  output logic        wbm1_rty_o,

  output logic [31:0] wbs_adr_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  wbs_sel_o,
  output logic        wbs_we_o,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  input  logic [31:0] wbs_dat_i,
  input  logic        wbs_ack_i,
  input  logic        wbs_err_i,
  input  logic        wbs_rty_i
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("wb_master_arbiter: TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state, state_nxt;
  logic   last_gnt, last_gnt_nxt;   // 0 = master 0, 1 = master 1
  logic   timeout;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    unique case (state)
      IDLE: begin
        if (wbm0_cyc_i && wbm1_cyc_i) begin
          state_nxt    = last_gnt ? GNT0 : GNT1;
          last_gnt_nxt = ~last_gnt;
        end else if (wbm0_cyc_i) begin
          state_nxt    = GNT0;
          last_gnt_nxt = 1'b0;
        end else if (wbm1_cyc_i) begin
          state_nxt    = GNT1;
          last_gnt_nxt = 1'b1;
        end
      end
      GNT0:    if (!wbm0_cyc_i) state_nxt = IDLE;
      GNT1:    if (!wbm1_cyc_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] to_cnt;

  // A genuine ack in the expiry cycle wins over the watchdog.
  assign timeout = (state != IDLE) && (to_cnt == 8'(TIMEOUT_CYCLES)) && !wbs_ack_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      to_cnt <= '0;
    end else if (state == IDLE || wbs_ack_i || wbs_err_i || wbs_rty_i || timeout) begin
      to_cnt <= '0;
    end else if (wbs_cyc_o && wbs_stb_o) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;

  always_comb begin
    wbs_adr_o  = '0;
    wbs_dat_o  = '0;
    wbs_sel_o  = '0;
    wbs_we_o   = 1'b0;
    wbs_cyc_o  = 1'b0;
    wbs_stb_o  = 1'b0;
    wbm0_ack_o = 1'b0;
    wbm0_err_o = 1'b0;
    wbm0_rty_o = 1'b0;
    wbm1_ack_o = 1'b0;
    wbm1_err_o = 1'b0;
    wbm1_rty_o = 1'b0;
    unique case (state)
      GNT0: begin
        wbs_adr_o  = wbm0_adr_i;
        wbs_dat_o  = wbm0_dat_i;
        wbs_sel_o  = wbm0_sel_i;
        wbs_we_o   = wbm0_we_i;
        wbs_cyc_o  = wbm0_cyc_i;
        wbs_stb_o  = wbm0_stb_i && !timeout;
        wbm0_ack_o = wbs_ack_i;
        wbm0_err_o = wbs_err_i || timeout;
        wbm0_rty_o = wbs_rty_i;
      end
      GNT1: begin
        wbs_adr_o  = wbm1_adr_i;
        wbs_dat_o  = wbm1_dat_i;
        wbs_sel_o  = wbm1_sel_i;
        wbs_we_o   = wbm1_we_i;
        wbs_cyc_o  = wbm1_cyc_i;
        wbs_stb_o  = wbm1_stb_i && !timeout;
        wbm1_ack_o = wbs_ack_i;
        wbm1_err_o = wbs_err_i || timeout;
        wbm1_rty_o = wbs_rty_i;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/wb_master_arbiter.md
WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, legal range 1..255: cycles an unanswered strobe waits before a bus error.
REQ-002 SHALL have port wb_clk_i  in  1  system clock, all state on rising edge.
REQ-003 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports wbm0_adr_i / wbm1_adr_i  in  32  address; master 0 = instruction fetch, master 1 = data/load-store.
REQ-005 SHALL have ports wbm0_dat_i / wbm1_dat_i  in  32  write data.
REQ-006 SHALL have ports wbm0_sel_i / wbm1_sel_i  in  4  byte selects.
REQ-007 SHALL have ports wbm0_we_i / wbm1_we_i  in  1  write enable.
REQ-008 SHALL have ports wbm0_cyc_i / wbm1_cyc_i  in  1  bus cycle request.
REQ-009 SHALL have ports wbm0_stb_i / wbm1_stb_i  in  1  strobe.
REQ-010 SHALL have ports wbm0_dat_o / wbm1_dat_o  out  32  read data.
REQ-011 SHALL have ports wbm0_ack_o / wbm1_ack_o, wbm0_err_o / wbm1_err_o, wbm0_rty_o / wbm1_rty_o  out  1 each  termination.
REQ-012 SHALL have ports wbs_adr_o 32, wbs_dat_o 32, wbs_sel_o 4, wbs_we_o 1, wbs_cyc_o 1, wbs_stb_o 1  out  single master port into the interconnect's IO master side.
REQ-013 SHALL have ports wbs_dat_i 32, wbs_ack_i 1, wbs_err_i 1, wbs_rty_i 1  in  interconnect responses.

Function
REQ-014 SHALL implement FSM states IDLE, GNT0, GNT1, held in registers.
REQ-015 IDLE: only wbm0_cyc_i high -> GNT0; only wbm1_cyc_i high -> GNT1; both high -> grant the master not recorded in last_gnt; neither -> stay IDLE.
REQ-016 last_gnt SHALL update to the granted master on every IDLE->GNTx transition; reset value = master 1, so master 0 wins the first tie.
REQ-017 Grant latency SHALL be exactly one cycle: request seen in IDLE at edge N, wbs_cyc_o driven from cycle N+1.
REQ-018 GNTx SHALL hold while wbmx_cyc_i is high (multi-beat/locked cycles never interrupted); wbmx_cyc_i low -> IDLE next edge.
REQ-019 In IDLE, wbs_cyc_o and wbs_stb_o SHALL be 0; wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o SHALL be 0.
REQ-020 In GNTx, all wbs_* outputs SHALL be combinational copies of master x's inputs.
REQ-021 wbs_ack_i, wbs_err_i, wbs_rty_i SHALL route only to the granted master; the other master's ack/err/rty SHALL be 0; in IDLE all six are 0.
REQ-022 wbm0_dat_o and wbm1_dat_o SHALL both equal wbs_dat_i at all times.
REQ-023 Responses arriving while IDLE SHALL be dropped.
REQ-024 Switching SHALL always pass through one IDLE cycle, so back-to-back grants to different masters are separated by exactly one idle cycle.

Reset
REQ-025 wb_rst_i high SHALL immediately force IDLE, last_gnt = master 1, timeout counter = 0, and all outputs to 0, including mid-transfer.
REQ-026 After reset deassertion, first arbitration SHALL occur on the first rising edge with wb_rst_i low.

Configuration
REQ-027 Macro WB_ARB_TIMEOUT_EN SHALL compile in an 8-bit watchdog counter; without it no counter exists and an unanswered strobe waits forever.
REQ-028 With WB_ARB_TIMEOUT_EN, the counter SHALL increment each cycle wbs_cyc_o & wbs_stb_o is high with ack/err/rty all low, and clear on any termination, on entry to IDLE, or on reset.
REQ-029 When the counter equals TIMEOUT_CYCLES, the granted master's err SHALL pulse for exactly one cycle, wbs_stb_o SHALL be forced 0 that cycle, and the counter SHALL clear; a genuine wbs_ack_i in the same cycle SHALL take priority (ack passed, no err).

Verification
REQ-030 Only wbm0 requests one read, slave acks 2 cycles after stb with 0xDEADBEEF -> wbs_cyc_o rises 1 cycle after request; wbm0_ack_o=1 with wbm0_dat_o=0xDEADBEEF; wbm1_ack_o stays 0.
REQ-031 Both cyc rise on the same edge after reset -> GNT0 first; after wbm0 drops cyc, one IDLE cycle, then GNT1.
REQ-032 wbm1 holds cyc for 4 acked beats while wbm0 requests -> no switch until wbm1_cyc_i drops; then wbm0 granted.
REQ-033 WB_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, slave never responds -> wbmx_err_o pulses after 4 stalled cycles, wbs_stb_o=0 that cycle; undefined -> no err after 300 cycles.
REQ-034 Assert wb_rst_i mid-transfer in GNT1 -> all outputs 0 in the same cycle; after release, simultaneous requests grant master 0.
